// File: rtl/file_ram_writer.sv
// Packs incoming codes into wide words and stores them in on-chip RAM, with a registered read port.
// There is no backpressure: codes arriving while the RAM is full are dropped and flagged as overflow.
module file_ram_writer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int CODE_WIDTH = 16,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  valid,
    input  logic [CODE_WIDTH-1:0] data_in,
    input  logic                  eof,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [ADDR_WIDTH+2:0] code_count,
    output logic                  full,
    output logic                  overflow,
    output logic                  done
);

    localparam int LANES  = DATA_WIDTH / CODE_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d;
    logic [ADDR_WIDTH:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH+2:0]   code_cnt_q, code_cnt_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    logic                    full_w;
    logic                    wr_en;
    logic [MEM_AW-1:0]       wr_addr;
    logic [DATA_WIDTH-1:0]   wr_dat;
    logic [DATA_WIDTH-1:0]   ins_dat;
    logic                    rd_in_range;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign full_w      = (word_cnt_q == DEPTH_W);
    assign wr_addr     = word_cnt_q[MEM_AW-1:0];
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        buf_d      = buf_q;
        word_cnt_d = word_cnt_q;
        code_cnt_d = code_cnt_q;
        ovf_d      = ovf_q;
        wr_en      = 1'b0;
        wr_dat     = buf_q;
        ins_dat    = buf_q;
        ins_dat[lane_q*CODE_WIDTH +: CODE_WIDTH] = data_in;

        case (state_q)
            ST_ACCEPT: begin
                if (cs && valid) begin
                    // Only a code that would open a new word can hit a full RAM.
                    if (full_w && (lane_q == '0)) begin
                        ovf_d = 1'b1;
                    end else begin
                        if (code_cnt_q != '1) begin
                            code_cnt_d = code_cnt_q + 1'b1;
                        end
                        if (lane_q == LAST_LANE) begin
                            wr_en      = 1'b1;
                            wr_dat     = ins_dat;
                            word_cnt_d = word_cnt_q + 1'b1;
                            buf_d      = '0;
                            lane_d     = '0;
                        end else begin
                            buf_d  = ins_dat;
                            lane_d = lane_q + 1'b1;
                        end
                    end
                end
                if (cs && eof) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Unfilled upper lanes are already zero in the buffer.
                if (lane_q != '0) begin
                    wr_en      = 1'b1;
                    wr_dat     = buf_q;
                    word_cnt_d = word_cnt_q + 1'b1;
                    buf_d      = '0;
                    lane_d     = '0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACCEPT;
            lane_q     <= '0;
            buf_q      <= '0;
            word_cnt_q <= '0;
            code_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            buf_q      <= buf_d;
            word_cnt_q <= word_cnt_d;
            code_cnt_q <= code_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Non-blocking read of mem gives read-before-write on a same-edge collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_in_range) begin
            rd_data_q <= mem[rd_addr[MEM_AW-1:0]];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data    = rd_data_q;
    assign word_count = word_cnt_q;
    assign code_count = code_cnt_q;
    assign full       = full_w;
    assign overflow   = ovf_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_file_ram_writer.sv
// Directed bench for file_ram_writer: default-depth instance plus a DEPTH=4 instance for overflow.
module tb_file_ram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_a, cs_b;
    logic        valid;
    logic [15:0] data_in;
    logic        eof;
    logic [11:0] rd_addr;

    logic [63:0] rd_data_a, rd_data_b;
    logic [12:0] word_count_a, word_count_b;
    logic [14:0] code_count_a, code_count_b;
    logic        full_a, full_b, overflow_a, overflow_b, done_a, done_b;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    file_ram_writer dut_a (
        .clk(clk), .rst(rst), .cs(cs_a), .valid(valid), .data_in(data_in), .eof(eof),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .word_count(word_count_a),
        .code_count(code_count_a), .full(full_a), .overflow(overflow_a), .done(done_a)
    );

    file_ram_writer #(.DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .cs(cs_b), .valid(valid), .data_in(data_in), .eof(eof),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .word_count(word_count_b),
        .code_count(code_count_b), .full(full_b), .overflow(overflow_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic send(input logic [15:0] code);
        valid   = 1'b1;
        data_in = code;
        tick();
    endtask

    task automatic read_a(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        exp_q.push_back(exp);
        rd_addr = addr;
        tick();
        chk(tag, rd_data_a, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b1; cs_a = 1'b0; cs_b = 1'b0; valid = 1'b0;
        data_in = '0; eof = 1'b0; rd_addr = '0;
        #12;
        chk("rst_word_count", {51'd0, word_count_a}, 64'd0);
        chk("rst_code_count", {49'd0, code_count_a}, 64'd0);
        chk("rst_flags", {60'd0, full_a, overflow_a, done_a, 1'b0}, 64'd0);
        chk("rst_rd_data", rd_data_a, 64'd0);
        rst = 1'b0;
        tick();

        // Four codes fill one word, then eof.
        cs_a = 1'b1;
        send(16'h0041); send(16'h0042); send(16'h0042); send(16'h0100);
        chk("t1_word_count", {51'd0, word_count_a}, 64'd1);
        valid = 1'b0; eof = 1'b1;
        tick();
        chk("t1_done_eof_edge", {63'd0, done_a}, 64'd0);
        eof = 1'b0;
        tick();
        chk("t1_done", {63'd0, done_a}, 64'd1);
        chk("t1_word_count_end", {51'd0, word_count_a}, 64'd1);
        read_a("t1_mem0", 12'd0, 64'h0100_0042_0042_0041);

        // Five codes, eof on the fifth: partial word flushed.
        pulse_reset();
        send(16'h0041); send(16'h0042); send(16'h0042); send(16'h0100);
        eof = 1'b1;
        send(16'h0105);
        eof = 1'b0; valid = 1'b0;
        chk("t2_word_count_eof", {51'd0, word_count_a}, 64'd1);
        tick();
        chk("t2_word_count", {51'd0, word_count_a}, 64'd2);
        chk("t2_code_count", {49'd0, code_count_a}, 64'd5);
        chk("t2_done", {63'd0, done_a}, 64'd1);
        read_a("t2_mem1", 12'd1, 64'h0000_0000_0000_0105);
        read_a("t2_mem0", 12'd0, 64'h0100_0042_0042_0041);
        send(16'h0777);
        valid = 1'b0;
        chk("t2_done_ignores", {49'd0, code_count_a}, 64'd5);

        // eof with no codes: no write.
        pulse_reset();
        eof = 1'b1;
        tick();
        eof = 1'b0;
        chk("t3_done_eof_edge", {63'd0, done_a}, 64'd0);
        tick();
        chk("t3_done", {63'd0, done_a}, 64'd1);
        chk("t3_word_count", {51'd0, word_count_a}, 64'd0);
        read_a("t3_mem0_kept", 12'd0, 64'h0100_0042_0042_0041);

        // Reset mid-stream discards partial buffer.
        pulse_reset();
        send(16'h0009); send(16'h0008);
        valid = 1'b0;
        pulse_reset();
        send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
        valid = 1'b0;
        chk("t5_word_count", {51'd0, word_count_a}, 64'd1);
        chk("t5_code_count", {49'd0, code_count_a}, 64'd4);
        read_a("t5_mem0", 12'd0, 64'h0004_0003_0002_0001);

        // cs=0 blocks codes and eof.
        pulse_reset();
        cs_a = 1'b0;
        send(16'h00AA); send(16'h00BB);
        eof = 1'b1;
        send(16'h00CC);
        eof = 1'b0; valid = 1'b0;
        chk("t6_code_count", {49'd0, code_count_a}, 64'd0);
        chk("t6_word_count", {51'd0, word_count_a}, 64'd0);
        chk("t6_not_done", {63'd0, done_a}, 64'd0);
        rd_addr = 12'd1;
        #1;
        chk("t6_rd_holds", rd_data_a, 64'h0004_0003_0002_0001);
        read_a("t6_rd_latency", 12'd1, 64'h0000_0000_0000_0105);

        // Read-before-write on the same address.
        cs_a = 1'b1;
        send(16'h0005); send(16'h0006); send(16'h0007);
        rd_addr = 12'd0;
        exp_q.push_back(64'h0004_0003_0002_0001);
        exp_q.push_back(64'h0008_0007_0006_0005);
        send(16'h0008);
        valid = 1'b0;
        chk("rbw_old", rd_data_a, exp_q.pop_front());
        tick();
        chk("rbw_new", rd_data_a, exp_q.pop_front());
        cs_a = 1'b0;

        // DEPTH=4 instance: 17 codes, last one dropped.
        pulse_reset();
        cs_b = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            send(16'(i));
            if (i == 15) chk("t4_not_full_15", {63'd0, full_b}, 64'd0);
        end
        valid = 1'b0;
        chk("t4_full", {63'd0, full_b}, 64'd1);
        chk("t4_no_ovf_yet", {63'd0, overflow_b}, 64'd0);
        send(16'd17);
        valid = 1'b0;
        chk("t4_overflow", {63'd0, overflow_b}, 64'd1);
        chk("t4_word_count", {51'd0, word_count_b}, 64'd4);
        chk("t4_code_count", {49'd0, code_count_b}, 64'd16);
        exp_q.push_back(64'h0010_000F_000E_000D);
        rd_addr = 12'd3;
        tick();
        chk("t4_mem3", rd_data_b, exp_q.pop_front());
        tick();
        chk("t4_overflow_sticky", {63'd0, overflow_b}, 64'd1);
        cs_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
